rsa_decrypt: RTL and testbench
==============================

# rsa_decrypt

- Recovers a 32-bit plaintext word from an RSA ciphertext by modular exponentiation, m = c^d mod n.
- The private exponent d, modulus n and ciphertext c are inputs.
- This is the receive-side counterpart of the encryption top: same load/start/ready handshake, opposite direction.
- Self-contained: it runs its own square-and-multiply sequencer over a shared bit-serial modular multiplier.

## Interface
- WIDTH, 32, operand width in bits for key, modulus, ciphertext and plaintext.
- clk  input  1  rising-edge clock. One clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- key  input  WIDTH  private exponent d.
- n  input  WIDTH  modulus.
- ciphertext  input  WIDTH  ciphertext c.
- load  input  1  captures key, n and ciphertext into internal registers.
- decrypt  input  1  starts decryption on the registered operands.
- ready  output  1  result valid; level signal.
- error  output  1  operands were illegal on the last decrypt; level signal.
- plaintext  output  WIDTH  decrypted word m.

## Operation
- **load:** when the block is not busy, load=1 registers key, n and ciphertext. It also clears ready and error.
- **Ignored inputs:** load and decrypt are both ignored while busy.
- **decrypt:** when not busy, decrypt=1 starts a run. The start clears ready and error. If load and decrypt are high in the same cycle, load wins and decrypt is ignored.
- **FSM states:** IDLE, CHECK, MUL, SQR, DONE.
- **IDLE:** waits for decrypt.
- **CHECK (1 cycle):**
  - If n<2 or c>=n: set error=1, plaintext=0, go to DONE.
  - Otherwise: result=1, base=c, bit index i=0, go to MUL if key[0] else SQR.
- **MUL:** result = result*base mod n. Go to SQR when i<WIDTH-1, else DONE.
- **SQR:** base = base*base mod n, then i=i+1. Go to MUL if key[i] else SQR. The square after the final bit is skipped.
- **Multiplier:** both MUL and SQR use a single multiplier instance (Blakley interleaved shift-add). Per step, MSB first:
  - R = 2R + (a_j ? b : 0);
  - then subtract n up to twice, until R<n.
  - R is held in WIDTH+2 bits. Inputs are always <n, so the output is always <n.
- **DONE:** loads plaintext=result (0 on error), sets ready=1, then returns to IDLE.
- **Output hold:** ready, error and plaintext hold until the next accepted load or decrypt.
- **key=0:** plaintext=1, provided n is legal.

## Timing
- **Reset values:** reset_n low forces all of the following, asynchronously, including mid-run:
  - FSM to IDLE;
  - ready=0, error=0, plaintext=0;
  - operand registers to 0;
  - multiplier state cleared.
- **Multiplier:** one multiply is WIDTH+1 cycles: 1 setup cycle, then WIDTH iteration cycles. done pulses in the last of these cycles.
- **Latency:** measured from the decrypt-accepting edge to the edge raising ready.
  - Legal operands: 2 + (popcount(key) + WIDTH-1)*(WIDTH+1) cycles.
  - Illegal operands: 2 cycles.
- **Throughput:** the next decrypt is accepted no earlier than the cycle after ready rises.

## Structure
- Shared package `rsa_pkg` holds:
  - the WIDTH default;
  - the FSM state encoding;
  - the LEGAL_MIN_N=2 constant.
- Sub-module `mod_mul_blakley`:
  - Ports: clk, reset_n, start, a, b, n, done, product. Parameter: WIDTH.
  - Owns the iteration counter and the conditional-subtract datapath.
- Top level owns the operand registers, the exponent bit index and the FSM.

## Test plan
- **Small modulus:** load n=143, key=103, c=48, then decrypt → plaintext=9, error=0. ready rises exactly 2+(5+31)*33=1190 cycles after decrypt.
- **Textbook key:** load n=3233, key=2753, c=2790, then decrypt → plaintext=65.
- **Zero exponent:** load n=3233, key=0, c=2790 → plaintext=1 after 2+31*33=1025 cycles.
- **Illegal operands:**
  - n=1 → error=1, plaintext=0, ready after 2 cycles.
  - n=100, c=100 → same response.
- **Inputs while busy:** assert load with new values and decrypt mid-run → both ignored; the result matches the original operands.
- **Reset mid-run:** pull reset_n low mid-run → ready, error and plaintext are 0 immediately, without waiting for a clock edge. After release, load n=143, key=103, c=48 and decrypt → plaintext=9.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA blocks: default operand width, sequencer
// state encoding and the smallest modulus the hardware accepts.
package rsa_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int LEGAL_MIN_N   = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MUL   = 3'd2,
    SQR   = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mod_mul_blakley.sv
// Bit-serial Blakley modular multiplier: product = a*b mod n, one bit of a per
// cycle MSB first, with the running remainder kept below n every step.
module mod_mul_blakley
  import rsa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q, b_q, n_q;
  logic [WIDTH+1:0] r_q, r_nx;
  logic [CW-1:0]    cnt;
  logic             busy;

  // 2R + b < 3n because R < n and b < n, so two conditional subtracts suffice.
  always_comb begin
    logic [WIDTH+1:0] n_ext;
    logic [WIDTH+1:0] acc;
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    n_ext = {2'b00, n_q};
    acc   = (r_q << 1) + (a_q[cnt] ? {2'b00, b_q} : '0);
    if (acc >= n_ext) acc = acc - n_ext;
    if (acc >= n_ext) acc = acc - n_ext;
    r_nx  = acc;
  end

  // done is high during the final iteration cycle, with the finished product
  // visible combinationally so the sequencer can consume it on that edge.
  assign done    = busy && (cnt == '0);
  assign product = r_nx[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      n_q  <= '0;
      r_q  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      a_q  <= a;
      b_q  <= b;
      n_q  <= n;
      r_q  <= '0;
      cnt  <= CW'(WIDTH - 1);
      busy <= 1'b1;
    end else if (busy) begin
      r_q <= r_nx;
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/rsa_decrypt.sv
// RSA decryption top: m = c^d mod n by right-to-left square-and-multiply,
// sharing one Blakley multiplier between the multiply and square steps.
module rsa_decrypt
  import rsa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] ciphertext,
  input  logic             load,
  input  logic             decrypt,
  output logic             ready,
  output logic             error,
  output logic [WIDTH-1:0] plaintext
);

  localparam int             IW       = $clog2(WIDTH);
  localparam logic [IW-1:0]  LAST_IDX = IW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] key_q, n_q, c_q;
  logic [WIDTH-1:0] result, base;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_nx;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_product;

  // Operands are sampled on the multiplier's setup edge, one cycle after the
  // state change, so result/base already hold their updated values.
  assign mul_a  = (state == MUL) ? result : base;
  assign idx_nx = idx + 1'b1;

  mod_mul_blakley #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (mul_a),
    .b       (base),
    .n       (n_q),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      key_q     <= '0;
      n_q       <= '0;
      c_q       <= '0;
      result    <= '0;
      base      <= '0;
      idx       <= '0;
      mul_start <= 1'b0;
      ready     <= 1'b0;
      error     <= 1'b0;
      plaintext <= '0;
    end else begin
      mul_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            key_q <= key;
            n_q   <= n;
            c_q   <= ciphertext;
            ready <= 1'b0;
            error <= 1'b0;
          end else if (decrypt) begin
            ready <= 1'b0;
            error <= 1'b0;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (n_q < WIDTH'(LEGAL_MIN_N) || c_q >= n_q) begin
            error  <= 1'b1;
            result <= '0;
            state  <= DONE;
          end else begin
            result    <= WIDTH'(1);
            base      <= c_q;
            idx       <= '0;
            mul_start <= 1'b1;
            state     <= key_q[0] ? MUL : SQR;
          end
        end
        MUL: begin
          if (mul_done) begin
            result <= mul_product;
            if (idx < LAST_IDX) begin
              mul_start <= 1'b1;
              state     <= SQR;
            end else begin
              state <= DONE;
            end
          end
        end
        SQR: begin
          if (mul_done) begin
            base <= mul_product;
            idx  <= idx_nx;
            if (key_q[idx_nx]) begin
              mul_start <= 1'b1;
              state     <= MUL;
            end else if (idx_nx == LAST_IDX) begin
              state <= DONE;
            end else begin
              mul_start <= 1'b1;
              state     <= SQR;
            end
          end
        end
        DONE: begin
          plaintext <= result;
          ready     <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_decrypt.sv
// Directed bench for rsa_decrypt: hand-computed plaintexts, latencies,
// illegal operands, busy-input rejection and asynchronous reset.
module tb_rsa_decrypt;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] key, n, ciphertext;
  logic         load, decrypt;
  logic         ready, error;
  logic [W-1:0] plaintext;

  int checks = 0;
  int errors = 0;
  int lat;

  rsa_decrypt #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key        (key),
    .n          (n),
    .ciphertext (ciphertext),
    .load       (load),
    .decrypt    (decrypt),
    .ready      (ready),
    .error      (error),
    .plaintext  (plaintext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_ops(input logic [W-1:0] nn, input logic [W-1:0] kk, input logic [W-1:0] cc);
    @(negedge clk);
    n = nn; key = kk; ciphertext = cc; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic accept_decrypt();
    @(negedge clk);
    decrypt = 1'b1;
    @(posedge clk);
    #1 decrypt = 1'b0;
  endtask

  // Counts edges after the accepting edge until ready is seen high.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk);
      cycles++;
      #1;
      if (ready) break;
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] nn, input logic [W-1:0] kk,
                     input logic [W-1:0] cc, input logic [W-1:0] exp_pt,
                     input logic exp_err, input int exp_lat);
    load_ops(nn, kk, cc);
    check({tag, "_load_clears_ready"}, W'(ready), W'(0));
    accept_decrypt();
    wait_ready(lat);
    check({tag, "_ready"}, W'(ready), W'(1));
    check({tag, "_latency"}, W'(lat), W'(exp_lat));
    check({tag, "_plaintext"}, plaintext, exp_pt);
    check({tag, "_error"}, W'(error), W'(exp_err));
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; decrypt = 1'b0;
    key = '0; n = '0; ciphertext = '0;
    #23;
    check("reset_ready", W'(ready), W'(0));
    check("reset_error", W'(error), W'(0));
    check("reset_plaintext", plaintext, W'(0));
    @(negedge clk);
    reset_n = 1'b1;

    run("small", 143, 103, 48, 9, 1'b0, 1190);
    repeat (5) @(negedge clk);
    check("hold_ready", W'(ready), W'(1));
    check("hold_plaintext", plaintext, W'(9));

    run("textbook", 3233, 2753, 2790, 65, 1'b0, 1190);
    run("zero_exp", 3233, 0, 2790, 1, 1'b0, 1025);
    run("n_one", 1, 5, 0, 0, 1'b1, 2);
    run("c_eq_n", 100, 5, 100, 0, 1'b1, 2);

    // New operands and a second decrypt while busy must be dropped.
    load_ops(143, 103, 48);
    accept_decrypt();
    repeat (50) @(negedge clk);
    n = 3233; key = 2753; ciphertext = 2790; load = 1'b1; decrypt = 1'b1;
    repeat (3) @(negedge clk);
    load = 1'b0; decrypt = 1'b0;
    wait_ready(lat);
    check("busy_ready", W'(ready), W'(1));
    check("busy_plaintext", plaintext, W'(9));
    check("busy_error", W'(error), W'(0));

    // Asynchronous reset away from any clock edge while a run is in flight.
    load_ops(3233, 2753, 2790);
    accept_decrypt();
    repeat (200) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrun_ready", W'(ready), W'(0));
    check("midrun_error", W'(error), W'(0));
    check("midrun_plaintext", plaintext, W'(0));
    @(negedge clk);
    reset_n = 1'b1;
    run("after_reset", 143, 103, 48, 9, 1'b0, 1190);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
